// File: rtl/fault_test_pkg.sv
// Shared types and sizing for the exhaustive 3-input fault test sequencer.
package fault_test_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Settle delay: load arms the timer, expire_o is high during the last settle cycle.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned TMR_W = 4;

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Expire is registered one count early so it lines up with the final settle cycle.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d    = TMR_W'(SETTLE_CYCLES);
      expire_d = (SETTLE_CYCLES == 1);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - TMR_W'(1);
      expire_d = (cnt_q == TMR_W'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/fault_test_sequencer.sv
// Applies all input vectors to a good and a fault-injected circuit and
// records how many vectors produced differing outputs.
module fault_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned VEC_W         = fault_test_pkg::VEC_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             z_good,
  input  logic                             z_fault,
  output logic                             x1,
  output logic                             x2,
  output logic                             x3,
  output logic                             busy,
  output logic                             done,
  output logic                             fault_detected,
  output logic [fault_test_pkg::CNT_W-1:0] mismatch_count,
  output logic [VEC_W-1:0]                 first_fail_vec
);

  import fault_test_pkg::*;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VECTORS);

  state_e           state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] x_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] first_q;

  logic timer_load_c;
  logic timer_expire;

  assign timer_load_c = (state_q == ST_APPLY);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load_c),
    .expire_o(timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // start alone decides here; abort has nothing to cancel
          if (start) begin
            state_q <= ST_APPLY;
            vec_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
          end
        end
        ST_APPLY, ST_SETTLE, ST_COMPARE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
          end else if (state_q == ST_APPLY) begin
            state_q <= ST_SETTLE;
          end else if (state_q == ST_SETTLE) begin
            if (timer_expire) state_q <= ST_COMPARE;
          end else begin
            if (z_good != z_fault) begin
              if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
              fault_q <= 1'b1;
              if (!fault_q) first_q <= vec_q;
            end
            // vec_q stays on the last vector in DONE instead of wrapping
            if (vec_q == LAST_VEC) begin
              state_q <= ST_DONE;
              x_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_APPLY;
              vec_q   <= vec_q + VEC_W'(1);
              x_q     <= vec_q + VEC_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          x_q     <= '0;
        end
      endcase
    end
  end

  assign {x1, x2, x3}   = x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fault_detected = fault_q;
  assign mismatch_count = cnt_q;
  assign first_fail_vec = first_q;

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Scoreboard bench for fault_test_sequencer: expected vectors and run results are
// queued when a run is launched and popped as the sequencer produces them.
module tb_fault_test_sequencer;

  localparam int unsigned SETTLE     = 2;
  localparam int unsigned PER_VEC    = SETTLE + 2;
  localparam int unsigned RUN_CYCLES = 8 * PER_VEC;

  typedef struct packed {
    logic [3:0] cnt;
    logic       fd;
    logic [2:0] ffv;
  } result_t;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       z_good, z_fault;
  logic       x1, x2, x3, busy, done, fault_detected;
  logic [3:0] mismatch_count;
  logic [2:0] first_fail_vec;
  logic [2:0] xv;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  logic [2:0] exp_x_q[$];
  result_t    exp_res_q[$];

  fault_test_sequencer #(.SETTLE_CYCLES(SETTLE), .VEC_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .z_good        (z_good),
    .z_fault       (z_fault),
    .x1            (x1),
    .x2            (x2),
    .x3            (x3),
    .busy          (busy),
    .done          (done),
    .fault_detected(fault_detected),
    .mismatch_count(mismatch_count),
    .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  // Circuit under test: parity; the faulty copy depends on the selected mode
  function automatic logic good_of(input logic [2:0] v);
    return ^v;
  endfunction

  function automatic logic fault_of(input int m, input logic [2:0] v);
    case (m)
      1:       return good_of(v) ^ (v == 3'b011);
      2:       return ~good_of(v);
      default: return good_of(v);
    endcase
  endfunction

  assign xv      = {x1, x2, x3};
  assign z_good  = good_of(xv);
  assign z_fault = fault_of(mode, xv);

  task automatic push_run(input int m);
    result_t r;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < int'(PER_VEC); c++) exp_x_q.push_back(3'(v));
      if (good_of(3'(v)) != fault_of(m, 3'(v))) begin
        if (!r.fd) r.ffv = 3'(v);
        r.fd  = 1'b1;
        r.cnt = r.cnt + 4'd1;
      end
    end
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Launches one run and checks every busy cycle plus the final results
  task automatic run_and_check(input int m, input string name, input int start_at, input bit with_abort);
    int         cyc;
    bit         seen_done;
    logic [2:0] ex;
    result_t    er, got;
    mode = m;
    push_run(m);
    pulse_start(with_abort);
    cyc       = 0;
    seen_done = 1'b0;
    for (int n = 0; n < int'(RUN_CYCLES) + 20; n++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      start = (n == start_at);
      if (!busy) begin
        checks++; errors++;
        $display("FAIL %s busy dropped at cycle %0d without done", name, n);
        break;
      end
      if (exp_x_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s extra busy cycle %0d x=%b", name, n, xv);
      end else begin
        ex = exp_x_q.pop_front();
        checks++;
        if (xv !== ex) begin
          errors++;
          $display("FAIL %s vector cycle %0d got x=%b expected %b", name, n, xv, ex);
        end
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s timeout waiting for done", name);
    end
    checks++;
    if (cyc != int'(RUN_CYCLES)) begin
      errors++;
      $display("FAIL %s run length got %0d cycles expected %0d", name, cyc, RUN_CYCLES);
    end
    checks++;
    if (exp_x_q.size() != 0) begin
      errors++;
      $display("FAIL %s vectors left unapplied got %0d expected 0", name, exp_x_q.size());
      exp_x_q.delete();
    end
    er  = exp_res_q.pop_front();
    got = '{cnt: mismatch_count, fd: fault_detected, ffv: first_fail_vec};
    checks++;
    if (got !== er) begin
      errors++;
      $display("FAIL %s result got cnt=%0d fd=%b ffv=%b expected cnt=%0d fd=%b ffv=%b",
               name, got.cnt, got.fd, got.ffv, er.cnt, er.fd, er.ffv);
    end
    checks++;
    if (xv !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done state got x=%b busy=%b expected x=000 busy=0", name, xv, busy);
    end
    repeat (3) @(negedge clk);
    got = '{cnt: mismatch_count, fd: fault_detected, ffv: first_fail_vec};
    checks++;
    if (done !== 1'b1 || got !== er) begin
      errors++;
      $display("FAIL %s hold in done got done=%b cnt=%0d expected done=1 cnt=%0d", name, done, got.cnt, er.cnt);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if ({busy, done, fault_detected, xv, mismatch_count, first_fail_vec} !== 13'd0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b fd=%b x=%b cnt=%0d ffv=%b expected all 0",
               name, busy, done, fault_detected, xv, mismatch_count, first_fail_vec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    @(negedge clk);
    check_cleared("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("idle_after_reset");
  endtask

  task automatic test_no_fault();
    run_and_check(0, "no_fault", -1, 1'b0);
  endtask

  task automatic test_single_fault();
    run_and_check(1, "single_fault_011", -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_and_check(2, "all_fault_from_done", -1, 1'b0);
  endtask

  task automatic test_start_in_settle();
    run_and_check(1, "start_in_settle_010", 2 * int'(PER_VEC) + 1, 1'b0);
  endtask

  task automatic test_start_beats_abort();
    run_and_check(2, "start_beats_abort", -1, 1'b1);
  endtask

  task automatic test_abort();
    mode = 2;
    pulse_start(1'b0);
    repeat (4 * PER_VEC + 3) @(negedge clk);
    checks++;
    if (xv !== 3'b100 || mismatch_count !== 4'd4) begin
      errors++;
      $display("FAIL abort_precondition got x=%b cnt=%0d expected x=100 cnt=4", xv, mismatch_count);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_cleared("abort_in_compare");
    @(negedge clk);
    check_cleared("abort_stays_idle");
  endtask

  task automatic test_reset_mid_run();
    mode = 2;
    pulse_start(1'b0);
    repeat (5 * PER_VEC + 1) @(negedge clk);
    checks++;
    if (xv !== 3'b101 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_precondition got x=%b busy=%b expected x=101 busy=1", xv, busy);
    end
    rst = 1'b1;
    #1;
    check_cleared("reset_immediate");
    @(negedge clk);
    check_cleared("reset_held");
    rst = 1'b0;
    run_and_check(0, "run_after_reset", -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_single_fault();
    test_back_to_back();
    test_start_in_settle();
    test_start_beats_abort();
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
